// File: rtl/plusarg_timeout_bank_if.sv
// Config write port of plusarg_timeout_bank: one valid/ready write of a
// channel limit per cycle.
interface plusarg_timeout_bank_if #(
  parameter int CW    = 2,
  parameter int WIDTH = 32
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CW-1:0]    cfg_chan;
  logic [WIDTH-1:0] cfg_data;

  modport master (output cfg_valid, output cfg_chan, output cfg_data, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_chan, input  cfg_data, output cfg_ready);
endinterface

// File: rtl/plusarg_timeout_bank.sv
// Bank of NCHAN watchdog channels, each with a runtime-writable cycle limit
// and a sticky timeout that fires when its activity window reaches the limit.
module plusarg_timeout_bank #(
  parameter string                    FORMAT  = "timeout=%d",
  parameter int                       NCHAN   = 4,
  parameter int                       WIDTH   = 32,
  parameter logic [NCHAN*WIDTH-1:0]   DEFAULT = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  plusarg_timeout_bank_if.slave    cfg,
  input  logic [NCHAN-1:0]         active,
  input  logic [NCHAN-1:0]         kick,
  input  logic [NCHAN-1:0]         clear,
  output logic [NCHAN*WIDTH-1:0]   limit,
  output logic [NCHAN*WIDTH-1:0]   count,
  output logic [NCHAN-1:0]         timeout,
  output logic                     timeout_any
);

  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  // FORMAT is a label only; the limits always come from DEFAULT.
  if (NCHAN < 1 || WIDTH < 1 || FORMAT == "") begin : g_param_check
    $error("plusarg_timeout_bank: illegal parameterisation");
  end

  typedef enum logic [1:0] {
    CH_DISABLED,
    CH_IDLE,
    CH_COUNT,
    CH_EXPIRED
  } chan_mode_e;

  logic rdy_q;

  always_ff @(posedge clock) begin
    if (reset) rdy_q <= 1'b0;
    else       rdy_q <= 1'b1;
  end

  assign cfg.cfg_ready = rdy_q;

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
    logic [WIDTH-1:0] cnt_inc;
    logic             wr_hit;
    chan_mode_e       mode;

    // Indices with no matching channel simply never hit, so they are dropped.
    assign wr_hit  = cfg.cfg_valid & rdy_q & (cfg.cfg_chan == CW'(i));
    assign cnt_inc = cnt_q + WIDTH'(1);

    always_comb begin
      if (to_q)               mode = CH_EXPIRED;
      else if (lim_q == '0)   mode = CH_DISABLED;
      else if (active[i])     mode = CH_COUNT;
      else                    mode = CH_IDLE;
    end

    // Priority: cfg write > clear > kick > increment/expire.
    always_comb begin
      lim_d = lim_q;
      cnt_d = cnt_q;
      to_d  = to_q;
      if (wr_hit) begin
        lim_d = cfg.cfg_data;
        cnt_d = '0;
        if (clear[i]) to_d = 1'b0;
      end else if (clear[i]) begin
        cnt_d = '0;
        to_d  = 1'b0;
      end else begin
        unique case (mode)
          CH_DISABLED, CH_IDLE: cnt_d = '0;
          CH_COUNT: begin
            if (kick[i]) begin
              cnt_d = '0;
            end else begin
              cnt_d = cnt_inc;
              if (cnt_inc == lim_q) to_d = 1'b1;
            end
          end
          CH_EXPIRED: ;
          default: ;
        endcase
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        lim_q <= DEFAULT[i*WIDTH +: WIDTH];
        cnt_q <= '0;
        to_q  <= 1'b0;
      end else begin
        lim_q <= lim_d;
        cnt_q <= cnt_d;
        to_q  <= to_d;
      end
    end

    assign limit[i*WIDTH +: WIDTH] = lim_q;
    assign count[i*WIDTH +: WIDTH] = cnt_q;
    assign timeout[i]              = to_q;
  end

  assign timeout_any = |timeout;

endmodule
